// File: rtl/game_sequencer_if.sv
// Signal bundle between the tic-tac-toe round controller and the rest of the game:
// move entry, board register, win checker and score updater.
interface game_sequencer_if;
    logic       start_btn;
    logic       player_symbol;
    logic       player_move_valid;
    logic [3:0] player_cell;
    logic       cpu_move_valid;
    logic [3:0] cpu_cell;
    logic [8:0] board_occupied;
    logic [5:0] winning;
    logic       update_done;
    logic       gameover;
    logic [2:0] state;
    logic       cell_we;
    logic [3:0] cell_addr;
    logic       cell_symbol;
    logic       board_clear;
    logic       cpu_req;
    logic       illegal_move;
    logic       turn_timeout;

    modport master (
        input  start_btn, player_symbol, player_move_valid, player_cell,
        input  cpu_move_valid, cpu_cell, board_occupied, winning, update_done, gameover,
        output state, cell_we, cell_addr, cell_symbol, board_clear, cpu_req,
        output illegal_move, turn_timeout
    );

    modport slave (
        output start_btn, player_symbol, player_move_valid, player_cell,
        output cpu_move_valid, cpu_cell, board_occupied, winning, update_done, gameover,
        input  state, cell_we, cell_addr, cell_symbol, board_clear, cpu_req,
        input  illegal_move, turn_timeout
    );
endinterface

// File: rtl/game_sequencer.sv
// Round/turn controller for tic-tac-toe: arbitrates board writes between the player and
// the computer, and sequences win checking, score update, board refresh and game over.
module game_sequencer #(
    parameter int unsigned CHECK_CYCLES   = 4,
    parameter int unsigned REFRESH_CYCLES = 8,
    parameter logic [23:0] TURN_TIMEOUT   = 24'd5_000_000,
    parameter int unsigned UPD_MIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    game_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        START_GAME     = 3'b000,
        PLAYER_TURN    = 3'b001,
        CPU_TURN       = 3'b010,
        CHECKING       = 3'b011,
        REFRESHING     = 3'b100,
        UPDATING_SCORE = 3'b101,
        GAME_OVER      = 3'b110
    } state_t;

    localparam logic [23:0] CHECK_LAST   = 24'(CHECK_CYCLES - 1);
    localparam logic [23:0] REFRESH_LAST = 24'(REFRESH_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = TURN_TIMEOUT - 24'd1;
    localparam logic [23:0] UPD_MIN      = 24'(UPD_MIN_CYCLES);

    state_t      state_reg, state_next;
    logic [23:0] cnt_reg, cnt_next;
    logic        symbol_reg, symbol_next;
    logic        first_cpu_reg, first_cpu_next;
    logic        last_cpu_reg, last_cpu_next;
    logic        cell_we_reg, cell_we_next;
    logic [3:0]  cell_addr_reg, cell_addr_next;
    logic        cell_symbol_reg, cell_symbol_next;
    logic        board_clear_reg, board_clear_next;
    logic        cpu_req_reg, cpu_req_next;
    logic        illegal_reg, illegal_next;
    logic        timeout_reg, timeout_next;

    // Free-cell lookup padded to 16 entries so out-of-range cells (9..15) read as taken.
    logic [15:0] free_mask;
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_free
            if (gi < 9) begin : g_cell
                assign free_mask[gi] = ~bus.board_occupied[gi];
            end else begin : g_pad
                assign free_mask[gi] = 1'b0;
            end
        end
    endgenerate

    logic player_legal, cpu_legal, board_full, unused_bits;
    assign player_legal = bus.player_move_valid & free_mask[bus.player_cell];
    assign cpu_legal    = bus.cpu_move_valid & free_mask[bus.cpu_cell];
    assign board_full   = &bus.board_occupied;
    assign unused_bits  = ^bus.winning[4:0];

    always_comb begin
        state_next       = state_reg;
        symbol_next      = symbol_reg;
        first_cpu_next   = first_cpu_reg;
        last_cpu_next    = last_cpu_reg;
        cell_we_next     = 1'b0;
        cell_addr_next   = cell_addr_reg;
        cell_symbol_next = cell_symbol_reg;
        illegal_next     = 1'b0;
        timeout_next     = 1'b0;
        case (state_reg)
            START_GAME: begin
                if (bus.start_btn) begin
                    symbol_next    = bus.player_symbol;
                    first_cpu_next = 1'b0;
                    state_next     = PLAYER_TURN;
                end
            end
            PLAYER_TURN: begin
                // A legal move on the expiry cycle takes priority over the forfeit.
                if (player_legal) begin
                    cell_we_next     = 1'b1;
                    cell_addr_next   = bus.player_cell;
                    cell_symbol_next = symbol_reg;
                    last_cpu_next    = 1'b0;
                    state_next       = CHECKING;
                end else begin
                    illegal_next = bus.player_move_valid;
                    if (cnt_reg == TIMEOUT_LAST) begin
                        timeout_next  = 1'b1;
                        last_cpu_next = 1'b0;
                        state_next    = CPU_TURN;
                    end
                end
            end
            CPU_TURN: begin
                if (cpu_legal) begin
                    cell_we_next     = 1'b1;
                    cell_addr_next   = bus.cpu_cell;
                    cell_symbol_next = ~symbol_reg;
                    last_cpu_next    = 1'b1;
                    state_next       = CHECKING;
                end
            end
            CHECKING: begin
                if (cnt_reg == CHECK_LAST) begin
                    // A full board the checker did not flag is still the end of the round.
                    if (bus.winning[5] || board_full) begin
                        state_next = UPDATING_SCORE;
                    end else if (last_cpu_reg) begin
                        state_next = PLAYER_TURN;
                    end else begin
                        state_next = CPU_TURN;
                    end
                end
            end
            UPDATING_SCORE: begin
                if (bus.update_done && (cnt_reg >= UPD_MIN)) begin
                    if (bus.gameover) begin
                        state_next = GAME_OVER;
                    end else begin
                        first_cpu_next = ~first_cpu_reg;
                        state_next     = REFRESHING;
                    end
                end
            end
            REFRESHING: begin
                if (cnt_reg == REFRESH_LAST) begin
                    state_next = first_cpu_reg ? CPU_TURN : PLAYER_TURN;
                end
            end
            GAME_OVER: begin
                if (bus.start_btn) begin
                    state_next = START_GAME;
                end
            end
            default: state_next = START_GAME;
        endcase

        // One shared dwell/timeout counter: zero on entry to a state, saturating while in it.
        if (state_next != state_reg) begin
            cnt_next = 24'd0;
        end else if (cnt_reg != 24'hFF_FFFF) begin
            cnt_next = cnt_reg + 24'd1;
        end else begin
            cnt_next = cnt_reg;
        end

        board_clear_next = (state_next == START_GAME) || (state_next == REFRESHING);
        cpu_req_next     = (state_next == CPU_TURN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= START_GAME;
            cnt_reg         <= 24'd0;
            symbol_reg      <= 1'b0;
            first_cpu_reg   <= 1'b0;
            last_cpu_reg    <= 1'b0;
            cell_we_reg     <= 1'b0;
            cell_addr_reg   <= 4'd0;
            cell_symbol_reg <= 1'b0;
            board_clear_reg <= 1'b1;
            cpu_req_reg     <= 1'b0;
            illegal_reg     <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            symbol_reg      <= symbol_next;
            first_cpu_reg   <= first_cpu_next;
            last_cpu_reg    <= last_cpu_next;
            cell_we_reg     <= cell_we_next;
            cell_addr_reg   <= cell_addr_next;
            cell_symbol_reg <= cell_symbol_next;
            board_clear_reg <= board_clear_next;
            cpu_req_reg     <= cpu_req_next;
            illegal_reg     <= illegal_next;
            timeout_reg     <= timeout_next;
        end
    end

    assign bus.state        = state_reg;
    assign bus.cell_we      = cell_we_reg;
    assign bus.cell_addr    = cell_addr_reg;
    assign bus.cell_symbol  = cell_symbol_reg;
    assign bus.board_clear  = board_clear_reg;
    assign bus.cpu_req      = cpu_req_reg;
    assign bus.illegal_move = illegal_reg;
    assign bus.turn_timeout = timeout_reg;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed per-cycle vectors for game_sequencer: a table for the main round, then
// hand-written sequences for timeout, game over, board-full and mid-refresh reset.
module tb_game_sequencer;
    logic clk;
    logic rst;
    game_sequencer_if bus();

    game_sequencer #(.TURN_TIMEOUT(24'd16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst, start, psym, pmv;
        logic [3:0] pcell;
        logic       cmv;
        logic [3:0] ccell;
        logic [8:0] occ;
        logic [5:0] win;
        logic       upd, go;
    } in_t;

    typedef struct packed {
        logic [2:0] st;
        logic       we;
        logic [3:0] addr;
        logic       sym, clr, req, ill, tmo;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    function automatic in_t In(int r, int s, int ps, int pmv, int pc, int cmv, int cc,
                               int occ, int win, int upd, int go);
        in_t x;
        x.rst = 1'(r);   x.start = 1'(s);  x.psym = 1'(ps); x.pmv = 1'(pmv);
        x.pcell = 4'(pc); x.cmv = 1'(cmv); x.ccell = 4'(cc);
        x.occ = 9'(occ); x.win = 6'(win);  x.upd = 1'(upd); x.go = 1'(go);
        return x;
    endfunction

    function automatic exp_t E(int st, int we, int ad, int sy, int clr, int req, int ill, int tmo);
        exp_t x;
        x.st = 3'(st);  x.we = 1'(we);   x.addr = 4'(ad); x.sym = 1'(sy);
        x.clr = 1'(clr); x.req = 1'(req); x.ill = 1'(ill); x.tmo = 1'(tmo);
        return x;
    endfunction

    task automatic row(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t i);
        rst                   = i.rst;
        bus.start_btn         = i.start;
        bus.player_symbol     = i.psym;
        bus.player_move_valid = i.pmv;
        bus.player_cell       = i.pcell;
        bus.cpu_move_valid    = i.cmv;
        bus.cpu_cell          = i.ccell;
        bus.board_occupied    = i.occ;
        bus.winning           = i.win;
        bus.update_done       = i.upd;
        bus.gameover          = i.go;
    endtask

    // One clock per call: inputs held across the edge, outputs sampled 1ns after it.
    task automatic apply(input string nm, input in_t i, input exp_t e);
        exp_t a;
        drive(i);
        @(posedge clk);
        #1;
        a.st = bus.state;        a.we = bus.cell_we;     a.addr = bus.cell_addr;
        a.sym = bus.cell_symbol; a.clr = bus.board_clear; a.req = bus.cpu_req;
        a.ill = bus.illegal_move; a.tmo = bus.turn_timeout;
        vec_cnt++;
        if (a !== e) begin
            miss_cnt++;
            $display("FAIL %s: st/we/addr/sym/clr/req/ill/tmo got %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d/%0d/%0d/%0d",
                     nm, a.st, a.we, a.addr, a.sym, a.clr, a.req, a.ill, a.tmo,
                     e.st, e.we, e.addr, e.sym, e.clr, e.req, e.ill, e.tmo);
        end else begin
            $display("ok   %s: state=%0d we=%0d addr=%0d sym=%0d clr=%0d req=%0d ill=%0d tmo=%0d",
                     nm, a.st, a.we, a.addr, a.sym, a.clr, a.req, a.ill, a.tmo);
        end
    endtask

    initial begin
        // In(rst,start,psym,pmv,pcell,cmv,ccell,occ,win,upd,go)  E(st,we,addr,sym,clr,req,ill,tmo)
        row(In(1,0,0,0,0,0,0,0,0,0,0),          E(0,0,0,0,1,0,0,0));
        row(In(0,0,0,0,0,0,0,0,0,0,0),          E(0,0,0,0,1,0,0,0));
        row(In(0,1,1,0,0,0,0,0,0,0,0),          E(1,0,0,0,0,0,0,0));
        row(In(0,0,0,1,9,0,0,0,0,0,0),          E(1,0,0,0,0,0,1,0));
        row(In(0,0,0,1,4,0,0,'h010,0,0,0),      E(1,0,0,0,0,0,1,0));
        row(In(0,1,0,0,0,0,0,'h010,0,0,0),      E(1,0,0,0,0,0,0,0));
        row(In(0,0,0,1,0,0,0,'h010,0,0,0),      E(3,1,0,1,0,0,0,0));
        for (int k = 0; k < 3; k++)
            row(In(0,0,0,0,0,0,0,'h001,0,0,0),  E(3,0,0,1,0,0,0,0));
        row(In(0,0,0,0,0,0,0,'h001,0,0,0),      E(2,0,0,1,0,1,0,0));
        row(In(0,0,0,0,0,1,0,'h001,0,0,0),      E(2,0,0,1,0,1,0,0));
        row(In(0,0,0,1,5,1,12,'h001,0,0,0),     E(2,0,0,1,0,1,0,0));
        row(In(0,0,0,0,0,1,4,'h001,0,0,0),      E(3,1,4,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            row(In(0,0,0,0,0,0,0,'h011,'h30,0,0), E(3,0,4,0,0,0,0,0));
        row(In(0,0,0,0,0,0,0,'h011,'h30,0,0),   E(5,0,4,0,0,0,0,0));
        for (int k = 0; k < 2; k++)
            row(In(0,0,0,0,0,0,0,'h011,0,1,0),  E(5,0,4,0,0,0,0,0));
        row(In(0,0,0,0,0,0,0,'h011,0,1,0),      E(4,0,4,0,1,0,0,0));
        for (int k = 0; k < 7; k++)
            row(In(0,0,0,0,0,0,0,0,0,0,0),      E(4,0,4,0,1,0,0,0));
        row(In(0,0,0,0,0,0,0,0,0,0,0),          E(2,0,4,0,0,1,0,0));
        row(In(0,0,0,0,0,1,8,0,0,0,0),          E(3,1,8,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            row(In(0,0,0,0,0,0,0,'h100,0,0,0),  E(3,0,8,0,0,0,0,0));
        row(In(0,0,0,0,0,0,0,'h100,0,0,0),      E(1,0,8,0,0,0,0,0));

        drive(In(1,0,0,0,0,0,0,0,0,0,0));
        for (int k = 0; k < vecs.size(); k++)
            apply($sformatf("tbl%0d", k), vecs[k].i, vecs[k].e);

        // Idle player turn: forfeit on the 16th cycle, no board write.
        for (int k = 0; k < 15; k++)
            apply($sformatf("idle%0d", k), In(0,0,0,0,0,0,0,'h100,0,0,0), E(1,0,8,0,0,0,0,0));
        apply("timeout", In(0,0,0,0,0,0,0,'h100,0,0,0), E(2,0,8,0,0,1,0,1));
        apply("after_tmo", In(0,0,0,0,0,0,0,'h100,0,0,0), E(2,0,8,0,0,1,0,0));
        apply("cpu2", In(0,0,0,0,0,1,2,'h100,0,0,0), E(3,1,2,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            apply($sformatf("chk_b%0d", k), In(0,0,0,0,0,0,0,'h104,0,0,0), E(3,0,2,0,0,0,0,0));
        apply("to_player", In(0,0,0,0,0,0,0,'h104,0,0,0), E(1,0,2,0,0,0,0,0));
        for (int k = 0; k < 15; k++)
            apply($sformatf("wait%0d", k), In(0,0,0,0,0,0,0,'h104,0,0,0), E(1,0,2,0,0,0,0,0));
        apply("move_on_expiry", In(0,0,0,1,5,0,0,'h104,0,0,0), E(3,1,5,1,0,0,0,0));

        // Round over with gameover, restart, then board-full checker error.
        for (int k = 0; k < 3; k++)
            apply($sformatf("chk_c%0d", k), In(0,0,0,0,0,0,0,'h124,0,0,0), E(3,0,5,1,0,0,0,0));
        apply("draw", In(0,0,0,0,0,0,0,'h124,'h20,0,0), E(5,0,5,1,0,0,0,0));
        for (int k = 0; k < 2; k++)
            apply($sformatf("upd_mask%0d", k), In(0,0,0,0,0,0,0,0,0,1,1), E(5,0,5,1,0,0,0,0));
        apply("gameover", In(0,0,0,0,0,0,0,0,0,1,1), E(6,0,5,1,0,0,0,0));
        apply("go_hold", In(0,0,0,0,0,0,0,0,0,0,0), E(6,0,5,1,0,0,0,0));
        apply("go_start", In(0,1,0,0,0,0,0,0,0,0,0), E(0,0,5,1,1,0,0,0));
        apply("start_idle", In(0,0,0,0,0,0,0,0,0,0,0), E(0,0,5,1,1,0,0,0));
        apply("start_o", In(0,1,0,0,0,0,0,0,0,0,0), E(1,0,5,1,0,0,0,0));
        apply("move3", In(0,0,1,1,3,0,0,0,0,0,0), E(3,1,3,0,0,0,0,0));
        for (int k = 0; k < 3; k++)
            apply($sformatf("chk_d%0d", k), In(0,0,0,0,0,0,0,'h1FF,0,0,0), E(3,0,3,0,0,0,0,0));
        apply("board_full", In(0,0,0,0,0,0,0,'h1FF,0,0,0), E(5,0,3,0,0,0,0,0));
        for (int k = 0; k < 2; k++)
            apply($sformatf("upd_e%0d", k), In(0,0,0,0,0,0,0,0,0,1,0), E(5,0,3,0,0,0,0,0));
        apply("refresh", In(0,0,0,0,0,0,0,0,0,1,0), E(4,0,3,0,1,0,0,0));
        for (int k = 0; k < 2; k++)
            apply($sformatf("refresh%0d", k), In(0,0,0,0,0,0,0,0,0,0,0), E(4,0,3,0,1,0,0,0));
        apply("rst_mid_refresh", In(1,0,0,0,0,0,0,0,0,0,0), E(0,0,0,0,1,0,0,0));
        apply("post_rst", In(0,0,0,0,0,0,0,0,0,0,0), E(0,0,0,0,1,0,0,0));
        apply("post_rst_start", In(0,1,1,0,0,0,0,0,0,0,0), E(1,0,0,0,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level round/turn controller for the tic-tac-toe game.
- Drives the 3-bit game `state` bus consumed by the score/scoreboard updater.
- Arbitrates board writes between the human player (button/switch move entry) and the computer move generator.
- Sequences win checking, score update, board refresh, and game-over handling.

Parameters:
- CHECK_CYCLES, 4: cycles spent in CHECKING before `winning` is sampled, for win-checker settling; legal range 2..15.
- REFRESH_CYCLES, 8: cycles `board_clear` is held in REFRESHING; legal range 1..255.
- TURN_TIMEOUT, 24'd5_000_000: player-turn cycle limit. When it expires, the player's turn is forfeited to the computer.
- UPD_MIN_CYCLES, 2: cycles in UPDATING_SCORE before `update_done` is honoured. This masks a stale done from the previous round.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start_btn`, in, 1: one-cycle pulse (debounced) that starts a new game.
- `player_symbol`, in, 1: player's mark (0=O, 1=X); latched on leaving START_GAME.
- `player_move_valid`, in, 1: one-cycle pulse; player requests `player_cell`.
- `player_cell`, in, 4: requested cell 0..8.
- `cpu_move_valid`, in, 1: one-cycle pulse from the computer move generator.
- `cpu_cell`, in, 4: computer cell 0..8.
- `board_occupied`, in, 9: per-cell occupancy from the board register.
- `winning`, in, 6: win-checker result. [5]=round over (win or draw), [4]=win, [3]=winning symbol, [2:0] unused.
- `update_done`, in, 1: score updater finished.
- `gameover`, in, 1: score updater reports 3 wins reached.
- `state`, out, 3: game state code (encoding below).
- `cell_we`, out, 1: one-cycle board write strobe.
- `cell_addr`, out, 4: cell to write.
- `cell_symbol`, out, 1: mark to write.
- `board_clear`, out, 1: clear all cells.
- `cpu_req`, out, 1: level; asks the computer generator for a move.
- `illegal_move`, out, 1: one-cycle pulse on a rejected player move.
- `turn_timeout`, out, 1: one-cycle pulse on player forfeit.

Behaviour:
- State encoding (fixed, shared with the score updater):
  - START_GAME=000, PLAYER_TURN=001, CPU_TURN=010, CHECKING=011
  - REFRESHING=100, UPDATING_SCORE=101, GAME_OVER=110
- Reset (synchronous, `rst`=1 at a `clk` edge):
  - `state`=START_GAME.
  - All strobes (`cell_we`, `illegal_move`, `turn_timeout`) =0; `cpu_req`=0.
  - `board_clear`=1; `cell_addr`=0; `cell_symbol`=0.
  - All counters=0; first-mover flag=player.
  - Reset mid-operation aborts any turn, update, or refresh.
- START_GAME:
  - `board_clear`=1.
  - On `start_btn`: latch `player_symbol` and set first-mover=player.
  - Next cycle: PLAYER_TURN, `board_clear`=0.
- PLAYER_TURN:
  - Timeout counter increments every cycle.
  - On `player_move_valid`:
    - If `player_cell`>8 or the cell is occupied: pulse `illegal_move` and stay; the counter is not reset.
    - Otherwise: pulse `cell_we` with `cell_addr`=`player_cell`, `cell_symbol`=latched symbol, and go to CHECKING.
  - Counter reaching TURN_TIMEOUT-1 without a legal move: pulse `turn_timeout` and go to CPU_TURN with no board write.
  - Timeout and a legal move in the same cycle: the move wins.
- CPU_TURN:
  - `cpu_req`=1.
  - On `cpu_move_valid` with a legal cell: write with `cell_symbol`=~latched symbol, drop `cpu_req`, go to CHECKING.
  - Illegal computer cell: ignored, keep requesting.
  - `player_move_valid` is ignored here.
- CHECKING:
  - Dwell exactly CHECK_CYCLES cycles, then sample `winning`.
  - `winning[5]`=1: go to UPDATING_SCORE.
  - Otherwise: go to the opposite turn of the mover that entered CHECKING (a timeout-forfeit counts as a player turn).
  - Board full with `winning[5]`=0 is a checker error: treat as round over (go to UPDATING_SCORE).
- UPDATING_SCORE:
  - Dwell counter runs.
  - `update_done` is accepted only once the dwell is >= UPD_MIN_CYCLES.
  - On accepted done:
    - `gameover`=1: go to GAME_OVER.
    - Else: go to REFRESHING.
- REFRESHING:
  - `board_clear`=1 for exactly REFRESH_CYCLES cycles.
  - First-mover toggles once.
  - Then go to PLAYER_TURN or CPU_TURN per the new first-mover.
- GAME_OVER:
  - Hold with `board_clear`=0.
  - On `start_btn`: go to START_GAME.
- `start_btn` is ignored outside START_GAME and GAME_OVER.
- All outputs are registered: a board write occurs one cycle after the accepting edge, and `state` updates on the same edge as the transition.

Test Plan:
- `rst` pulse, then `start_btn`, `player_symbol`=1 → `state` 000→001; `board_clear` falls; `cell_we`=0 throughout.
- PLAYER_TURN: `player_cell`=9, then cell 4 with `board_occupied`[4]=1, then cell 0 free → two `illegal_move` pulses, then `cell_we` with addr 0, symbol 1; `state`=011 for 4 cycles, then 010 with `cpu_req`=1.
- CPU move cell 4, `winning`=6'b110000 in CHECKING → `state`=101; `update_done` held high from entry is ignored for 2 cycles; with `gameover`=0 → `state`=100 for 8 cycles with `board_clear`=1, then `state`=010 (first-mover toggled).
- Player idle for TURN_TIMEOUT (bench overrides to 16) → one `turn_timeout` pulse at cycle 16, `state`=010, no write; a legal move on cycle 16 instead → write, no timeout.
- UPDATING_SCORE with `update_done`=1, `gameover`=1 → `state`=110; `start_btn` → 000, `board_clear`=1; `rst` asserted during REFRESHING → next edge `state`=000, all strobes 0.
